// File: rtl/gpio_pad_conditioner.sv
// GPIO pad conditioner: per-pin synchronizer, optional debounce FSM, edge pulses and sticky IRQ flags.
// Define GPIO_DEBOUNCE_EN to build the per-pin settle counters; otherwise levels pass straight through.
module gpio_pad_conditioner #(
  parameter int NB_PINS     = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NB_PINS-1:0]   pad_in_i,
  input  logic [CNT_WIDTH-1:0] debounce_cfg_i,
  input  logic [NB_PINS-1:0]   bypass_i,
  input  logic [NB_PINS-1:0]   rise_en_i,
  input  logic [NB_PINS-1:0]   fall_en_i,
  input  logic [NB_PINS-1:0]   clr_i,
  output logic [NB_PINS-1:0]   gpio_in_o,
  output logic [NB_PINS-1:0]   rise_o,
  output logic [NB_PINS-1:0]   fall_o,
  output logic [NB_PINS-1:0]   pending_o,
  output logic                 irq_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [NB_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NB_PINS-1:0] x;
  logic [NB_PINS-1:0] s_q, s_d;
  logic [NB_PINS-1:0] rise_q, rise_d;
  logic [NB_PINS-1:0] fall_q, fall_d;
  logic [NB_PINS-1:0] pending_q, pending_d;

  // NOTE: the synchronizer array is reset like any other flop so a pad held
  // high through reset is seen as a fresh, debounced rise after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign x = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  typedef enum logic {STABLE = 1'b0, SETTLING = 1'b1} state_e;

  state_e               state_q [NB_PINS];
  state_e               state_d [NB_PINS];
  logic [CNT_WIDTH-1:0] cnt_q   [NB_PINS];
  logic [CNT_WIDTH-1:0] cnt_d   [NB_PINS];
  logic [CNT_WIDTH-1:0] eff_n   [NB_PINS];

  always_comb begin
    for (int p = 0; p < NB_PINS; p++) eff_n[p] = bypass_i[p] ? '0 : debounce_cfg_i;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NB_PINS; p++) begin
        state_q[p] <= STABLE;
        cnt_q[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < NB_PINS; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  // Next state. Using >= lets a lowered threshold end a settle on the next cycle.
  always_comb begin
    for (int p = 0; p < NB_PINS; p++) begin
      state_d[p] = state_q[p];
      if (x[p] == s_q[p]) state_d[p] = STABLE;
      else if (cnt_q[p] >= eff_n[p]) state_d[p] = STABLE;
      else state_d[p] = SETTLING;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    s_d = s_q;
    for (int p = 0; p < NB_PINS; p++) begin
      cnt_d[p] = '0;
      if (x[p] != s_q[p]) begin
        if (cnt_q[p] >= eff_n[p]) s_d[p] = x[p];
        else cnt_d[p] = cnt_q[p] + CNT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_debounce_inputs;
  assign unused_debounce_inputs = ^{debounce_cfg_i, bypass_i};
  assign s_d = x;
`endif

  assign rise_d    = s_d & ~s_q;
  assign fall_d    = ~s_d & s_q;
  // Set beats clear, so a clear racing a new edge never loses the event.
  assign pending_d = (pending_q & ~clr_i) | (rise_d & rise_en_i) | (fall_d & fall_en_i);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
    end else begin
      s_q       <= s_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign gpio_in_o = s_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;
  assign irq_o     = |pending_q;

endmodule
